// File: rtl/ps2_pkg.sv
// Shared byte constants, parser state and event layout for the PS/2 key-event controller.
package ps2_pkg;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  // Keyboard status/ack bytes that never form a key event from IDLE.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_EE) || (b == SC_FE);
  endfunction
endpackage

// File: rtl/ps2_ev_fifo.sv
// Synchronous FIFO with wrap-bit pointers; clr has priority over push and pop.
module ps2_ev_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot the same-cycle push needs when full.
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    wr_d = clr ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = clr ? '0 : rd_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Scan-code parser (E0/F0 prefixes, status filtering, typematic filter) feeding a key-event FIFO.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       enable,
  input  logic       flush,
  input  logic       pop,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_brk,
  output logic       ev_ext,
  output logic       overflow,
  output logic       proto_err
);
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [8:0]    held_q, held_d;
  logic          held_vld_q, held_vld_d;
  logic          ovf_q, ovf_d, perr_q, perr_d;
  logic          byte_acc, is_pfx, tmo_hit;
  logic          emit, em_ext, em_brk, key_hit, push;
  ps2_ev_t       ev_in, head;
  logic          fifo_full, fifo_empty;

  assign byte_acc = enable && rx_done;
  assign is_pfx   = (rx_data == SC_E0) || (rx_data == SC_F0);
  assign tmo_hit  = enable && !rx_done && (state_q != IDLE) && (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (byte_acc) begin
      case (state_q)
        IDLE:    state_d = (rx_data == SC_E0) ? EXT : (rx_data == SC_F0) ? BRK : IDLE;
        EXT:     state_d = (rx_data == SC_F0) ? EXT_BRK : (rx_data == SC_E0) ? EXT : IDLE;
        BRK:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  // Outputs: event emission and protocol error
  always_comb begin
    emit   = 1'b0;
    em_ext = 1'b0;
    em_brk = 1'b0;
    perr_d = tmo_hit;
    if (byte_acc) begin
      case (state_q)
        IDLE:    emit = !is_pfx && !is_status(rx_data);
        EXT:     begin emit = !is_pfx; em_ext = 1'b1; end
        BRK:     begin emit = !is_pfx; em_brk = 1'b1; perr_d = is_pfx; end
        EXT_BRK: begin emit = !is_pfx; em_brk = 1'b1; em_ext = 1'b1; perr_d = is_pfx; end
        default: emit = 1'b0;
      endcase
    end
  end

  // Typematic filter: a make matching the held key is a repeat and is dropped.
  always_comb begin
    key_hit    = held_vld_q && (held_q == {em_ext, rx_data});
    push       = emit && !flush && !(!em_brk && key_hit);
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (flush) begin
      held_vld_d = 1'b0;
    end else if (emit) begin
      if (!em_brk && !key_hit) begin
        held_d     = {em_ext, rx_data};
        held_vld_d = 1'b1;
      end else if (em_brk && key_hit) begin
        held_vld_d = 1'b0;
      end
    end
    ovf_d = flush ? 1'b0 : (ovf_q || (push && fifo_full && !pop));
    tmo_d = (state_q == IDLE || byte_acc || !enable || tmo_hit) ? '0 : tmo_q + 1'b1;
    ev_in = '{ext: em_ext, brk: em_brk, code: rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q      <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
    end
  end

  ps2_ev_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are zeroed while empty so stale entries never leak out.
  assign ev_valid  = !fifo_empty;
  assign ev_code   = ev_valid ? head.code : 8'h00;
  assign ev_brk    = ev_valid && head.brk;
  assign ev_ext    = ev_valid && head.ext;
  assign overflow  = ovf_q;
  assign proto_err = perr_q;
endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Controller between the PS/2 byte receiver and the keyboard-command FSMs. Parses the raw scan-code stream, including E0 extended and F0 break prefixes, and filters typematic repeats and keyboard status bytes. Queues complete key events in a small FIFO so that a consumer can pop them at its own pace. This replaces per-byte prefix handling in downstream state machines with one event-level handshake.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- TIMEOUT, 50000: clk cycles allowed between a prefix byte and its completing byte
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rx_done  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received scan-code byte
- enable  in  1  1 = parse bytes; 0 = ignore rx_done, parser forced to IDLE, FIFO contents kept
- flush  in  1  synchronous clear of FIFO, repeat filter and overflow
- pop  in  1  consumer takes head event (ignored when empty)
- ev_valid  out  1  FIFO non-empty
- ev_code  out  8  head event scan code (without prefixes)
- ev_brk  out  1  head event is a release
- ev_ext  out  1  head event was E0-prefixed
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- proto_err  out  1  one-cycle pulse: malformed sequence or timeout

## Operation
- Reset: parser IDLE, FIFO empty, repeat register cleared. All outputs are 0.
- Parser states:
  - IDLE: E0→EXT; F0→BRK; AA/FA/EE/FE discarded; any other byte emits make{ext=0}, stays IDLE.
  - EXT: F0→EXT_BRK; E0 stays EXT; other byte emits make{ext=1}→IDLE.
  - BRK: E0 or F0 triggers proto_err→IDLE, nothing emitted; other byte emits break{ext=0}→IDLE.
  - EXT_BRK: same as BRK, but the emitted break has ext=1.
- Timeout counter:
  - Cleared on every accepted byte and whenever in IDLE.
  - When it reaches TIMEOUT−1 in EXT/BRK/EXT_BRK without rx_done, the parser goes to IDLE and pulses proto_err.
  - Width is clog2(TIMEOUT).
- Repeat filter: 9-bit held register {ext,code} with a valid bit.
  - A make equal to the held key is dropped and is not queued.
  - A make of a different key is queued and overwrites held.
  - A break equal to held is queued and clears valid.
  - A break of any other key is queued; held is unchanged.
- FIFO: entries are 10 bits {ext,brk,code}, first-in first-out. Head is shown on ev_* whenever ev_valid=1.
  - Push when full with pop=0: the event is dropped and overflow is set.
  - Push and pop in the same cycle when full: both are performed, with no overflow.
  - Pop when empty: no effect.
- flush has priority over push and pop in the same cycle. Any same-cycle event is lost, and the parser state is untouched.
- Lowering enable mid-sequence returns the parser to IDLE silently, with no proto_err.

## Timing
- An event-completing rx_done sampled at edge k is written at edge k. ev_valid/ev_* are valid after edge k, giving 1-cycle latency.
- pop sampled at edge k advances the head at edge k. The next entry, or ev_valid=0, is visible after edge k.
- proto_err is registered and high for exactly the one cycle after the offending edge.
- Back-to-back rx_done on consecutive cycles must be accepted. Throughput is one byte per cycle.
- overflow stays high until flush or reset.

## Structure
- Package ps2_pkg:
  - byte constants E0, F0, AA, FA, EE, FE
  - parser state enum {IDLE, EXT, BRK, EXT_BRK}
  - event width constant (10)
- Sub-module ps2_ev_fifo: synchronous FIFO parameterised by DEPTH and width, with full/empty flags and registered pointers.
- Top level: parser FSM, timeout counter, repeat register, overflow flag.

## Test plan
- Byte 1C, then F0, 1C → two events: {0,0,1C} then {0,1,1C}. ev_valid rises 1 cycle after each completing byte.
- Byte E0, 75 three times, then E0, F0, 75 → exactly two events: {1,0,75} and {1,1,75}. The two repeat makes are filtered.
- DEPTH=4, no pops, six distinct makes → FIFO holds the first four, and overflow=1. Then pop and push in the same cycle while full → no loss, overflow unchanged. flush → ev_valid=0, overflow=0.
- Bytes F0, then no byte for TIMEOUT cycles → proto_err pulse. A following 1C is queued as make {0,0,1C}.
- Bytes FA, AA, then F0, F0 → no events queued, and one proto_err pulse. Assert rst low mid-sequence → all outputs 0 asynchronously.
